mips_fetch_queue: RTL and testbench

Instruction-fetch front end for the 5-stage MIPS pipeline. Issues word fetches to an instruction memory with variable-latency, in-order responses, buffers returned instructions in a small prefetch queue, and presents them to the IF/ID latch with a valid/stall handshake. A taken-branch redirect from decode flushes the queue and discards stale in-flight responses.

---
 rtl/mips_fetch_queue.sv | 102 ++++++++++
 tb/tb_mips_fetch_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_queue.sv
// Instruction-fetch front end: credit-limited word fetches to a variable-latency
// in-order memory, a DEPTH-entry prefetch queue, and redirect flush with stale-response discard.
module mips_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0020
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        ifid_valid,
    output logic [31:0] ifid_ir,
    output logic [31:0] ifid_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [31:0]   r_q_pc [DEPTH];
    logic [31:0]   r_q_ir [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;

    logic          w_xfer;
    logic          w_resp;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_redirect_pc;

    always_comb begin
        w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
        imem_req      = !reset && !redirect &&
                        (({1'b0, r_count} + {1'b0, r_outstanding}) < LIMIT);
        imem_addr     = r_fetch_pc;
        w_xfer        = imem_req && imem_ack;
        w_resp        = imem_rvalid && (r_outstanding != '0);
        w_push        = w_resp && (r_discard == '0);
        w_pop         = (r_count != '0) && !stall;
        ifid_valid    = (r_count != '0);
        ifid_ir       = ifid_valid ? r_q_ir[r_head] : NOP;
        ifid_pc       = ifid_valid ? r_q_pc[r_head] : '0;
    end

    // Requests within one fetch stream are consecutive words and all stale
    // responses precede the new stream, so a running pc replaces a per-request pc FIFO.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else if (redirect) begin
            r_fetch_pc    <= w_redirect_pc;
            r_resp_pc     <= w_redirect_pc;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_outstanding <= r_outstanding - CW'(w_resp);
            r_discard     <= r_outstanding - CW'(w_resp);
        end else begin
            if (w_xfer) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_outstanding <= r_outstanding + CW'(w_xfer) - CW'(w_resp);
            if (w_resp && (r_discard != '0)) begin
                r_discard <= r_discard - CW'(1);
            end
            if (w_push) begin
                r_tail    <= r_tail + AW'(1);
                r_resp_pc <= r_resp_pc + 32'd4;
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && !redirect && w_push) begin
            r_q_pc[r_tail] <= r_resp_pc;
            r_q_ir[r_tail] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Randomized scoreboard bench for mips_fetch_queue: memory model with epochs drives the DUT,
// expected queue contents are pushed on live responses and popped by a separate monitor.
module tb_mips_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0020;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        ifid_valid;
    logic [31:0] ifid_ir;
    logic [31:0] ifid_pc;

    mips_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP(NOP)) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stall      (stall),
        .ifid_valid (ifid_valid),
        .ifid_ir    (ifid_ir),
        .ifid_pc    (ifid_pc)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    ent_t        exp_q[$];
    req_t        pend[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          last_due = 0;
    logic [31:0] exp_fetch = RESET_PC;
    bit          mon_en = 0;

    int          lat_lo = 1, lat_hi = 1, p_stall = 0, p_redir = 0, p_ack = 100;
    bit          force_stall = 0, rst_req = 0, force_redir = 0, redir_on_resp = 0, hit = 0;
    logic [31:0] force_pc = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0041_2820;
            32'h4:   return 32'h8ca3_0004;
            32'h8:   return 32'haca7_0005;
            default: return (a * 32'h9e37_79b1) ^ 32'h5a5a_0000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock of memory model + stimulus: drive at +1, check request at +4, update model at +6.
    task automatic step();
        bit   resp_real;
        bit   xfer;
        logic exp_req;
        req_t r;
        int   due;
        @(posedge clock);
        #1;
        cyc++;
        reset       = rst_req;
        rst_req     = 0;
        stall       = force_stall ? 1'b1 : ($urandom_range(0, 99) < p_stall);
        redirect    = 1'b0;
        redirect_pc = $urandom;
        if (force_redir) begin
            redirect    = 1'b1;
            redirect_pc = force_pc;
            force_redir = 0;
        end else if ($urandom_range(0, 99) < p_redir) begin
            redirect = 1'b1;
        end
        imem_ack    = ($urandom_range(0, 99) < p_ack);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        resp_real   = 0;
        if (!reset) begin
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend[0].addr);
                resp_real   = 1;
            end else if (pend.size() == 0 && $urandom_range(0, 99) < 10) begin
                imem_rvalid = 1'b1;
            end
        end
        if (redir_on_resp && resp_real && exp_q.size() > 0) begin
            redirect      = 1'b1;
            stall         = 1'b0;
            redirect_pc   = $urandom;
            hit           = 1;
            redir_on_resp = 0;
        end
        #3;
        exp_req = !reset && !redirect && ((exp_q.size() + pend.size()) < DEPTH);
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (imem_req && exp_req) chk("imem_addr", imem_addr, exp_fetch);
        #2;
        xfer = imem_req && imem_ack;
        if (reset) begin
            exp_q.delete();
            pend.delete();
            exp_fetch = RESET_PC;
            epoch++;
            last_due = 0;
        end else begin
            if (resp_real) begin
                r = pend.pop_front();
                if (!redirect && r.epoch == epoch)
                    exp_q.push_back('{pc: r.addr, ir: mem_word(r.addr)});
            end
            if (redirect) begin
                exp_q.delete();
                epoch++;
                exp_fetch = redirect_pc & 32'hFFFF_FFFC;
            end else if (xfer) begin
                due = cyc + $urandom_range(lat_lo, lat_hi);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend.push_back('{addr: exp_fetch, due: due, epoch: epoch});
                exp_fetch = exp_fetch + 32'd4;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: compares the presented head against the scoreboard, pops on accept.
    initial begin
        ent_t e;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, (exp_q.size() != 0)});
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    chk("ifid_pc", ifid_pc, e.pc);
                    chk("ifid_ir", ifid_ir, e.ir);
                    if (!stall) void'(exp_q.pop_front());
                end else begin
                    chk("ifid_ir_empty", ifid_ir, NOP);
                    chk("ifid_pc_empty", ifid_pc, 32'h0);
                end
            end
        end
    end

    initial begin
        int n;
        bit found;
        rst_req = 1;
        step();
        mon_en = 1;
        rst_req = 1;
        step();

        // 1-cycle memory, no stall: words at 0,4,8 stream one per cycle.
        lat_lo = 1; lat_hi = 1; p_ack = 100; p_stall = 0; p_redir = 0;
        run(20);

        // Stall long enough to fill the queue, then release.
        force_stall = 1;
        run(8);
        force_stall = 0;
        run(10);

        // 3-cycle latency, redirect to 0x43 with two requests in flight.
        lat_lo = 3; lat_hi = 3;
        found = 0;
        n = 0;
        while (!found && n < 40) begin
            if (pend.size() == 2) found = 1;
            else begin step(); n++; end
        end
        chk("two_in_flight_reached", {31'b0, found}, 32'h1);
        force_redir = 1; force_pc = 32'h0000_0043;
        run(15);
        force_redir = 1; force_pc = 32'hFFFF_FFF9;
        run(12);

        // Redirect coinciding with a response and a pop.
        lat_lo = 2; lat_hi = 2; hit = 0; redir_on_resp = 1;
        run(60);
        redir_on_resp = 0;
        chk("redirect_on_response_hit", {31'b0, hit}, 32'h1);
        run(12);

        // Reset with a populated queue and two requests in flight.
        lat_lo = 8; lat_hi = 8; force_stall = 1;
        found = 0;
        n = 0;
        while (!found && n < 60) begin
            if (pend.size() == 2 && exp_q.size() >= 1) found = 1;
            else begin step(); n++; end
        end
        chk("reset_scenario_reached", {31'b0, found}, 32'h1);
        rst_req = 1;
        step();
        force_stall = 0;
        lat_lo = 1; lat_hi = 1;
        run(10);

        // Randomized blocks with varying memory and decode behaviour.
        for (int b = 0; b < 12; b++) begin
            lat_lo  = $urandom_range(1, 2);
            lat_hi  = lat_lo + $urandom_range(0, 4);
            p_stall = $urandom_range(0, 60);
            p_redir = $urandom_range(0, 8);
            p_ack   = $urandom_range(30, 100);
            if ($urandom_range(0, 3) == 0) rst_req = 1;
            run(250);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
